// File: rtl/aes_key_expander_pkg.sv
// Shared AES definitions: FSM encodings, last round index and GF(2^8) helpers.
// xtime is also used by the MixColumns stage.
package aes_key_expander_pkg;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_EXPAND = 2'd2;

  localparam logic [3:0] LAST_ROUND = 4'd10;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (square-and-multiply, exponent bits 1111_1110);
  // maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h01;
    for (int unsigned i = 0; i < 8; i++) begin
      r = gf_mul(r, r);
      if (i != 7) r = gf_mul(r, a);
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_key_expander_sbox.sv
// Forward AES S-box: GF(2^8) inverse followed by the affine transform.
// Shared between the key schedule (SubWord) and the round datapath.
module aes_sbox
  import aes_key_expander_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);

  logic [7:0] inv;

  always_comb begin
    inv = gf_inv(a);
    y   = inv
        ^ {inv[6:0], inv[7]}
        ^ {inv[5:0], inv[7:6]}
        ^ {inv[4:0], inv[7:5]}
        ^ {inv[3:0], inv[7:4]}
        ^ 8'h63;
  end

endmodule

// File: rtl/aes_key_expander.sv
// Iterative AES-128 key schedule: one round key per clock, 11 keys per start.
// The output register doubles as the key register the next round is derived from.
module aes_key_expander
  import aes_key_expander_pkg::*;
#(
  parameter int unsigned NR = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] K0, input logic [7:0] K1, input logic [7:0] K2, input logic [7:0] K3,
  input  logic [7:0] K4, input logic [7:0] K5, input logic [7:0] K6, input logic [7:0] K7,
  input  logic [7:0] K8, input logic [7:0] K9, input logic [7:0] KA, input logic [7:0] KB,
  input  logic [7:0] KC, input logic [7:0] KD, input logic [7:0] KE, input logic [7:0] KF,
  output logic [7:0] RK0, output logic [7:0] RK1, output logic [7:0] RK2, output logic [7:0] RK3,
  output logic [7:0] RK4, output logic [7:0] RK5, output logic [7:0] RK6, output logic [7:0] RK7,
  output logic [7:0] RK8, output logic [7:0] RK9, output logic [7:0] RKA, output logic [7:0] RKB,
  output logic [7:0] RKC, output logic [7:0] RKD, output logic [7:0] RKE, output logic [7:0] RKF,
  output logic [3:0] round_idx,
  output logic       rk_valid,
  output logic       busy,
  output logic       done
);

  logic [1:0]   state;
  logic [127:0] key_q;
  logic [7:0]   rcon_q;
  logic [127:0] key_in;
  logic [127:0] next_key;
  logic [31:0]  rot_w3;
  logic [31:0]  sub_w3;
  logic [31:0]  tmp;
  logic [31:0]  w0n, w1n, w2n, w3n;

  assign key_in = {K0, K1, K2, K3, K4, K5, K6, K7, K8, K9, KA, KB, KC, KD, KE, KF};
  assign {RK0, RK1, RK2, RK3, RK4, RK5, RK6, RK7,
          RK8, RK9, RKA, RKB, RKC, RKD, RKE, RKF} = key_q;

  assign rot_w3 = {key_q[23:0], key_q[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_subword
    aes_sbox u_sbox (
      .a (rot_w3[8*g +: 8]),
      .y (sub_w3[8*g +: 8])
    );
  end

  always_comb begin
    tmp      = sub_w3 ^ {rcon_q, 24'h000000};
    w0n      = key_q[127:96] ^ tmp;
    w1n      = key_q[95:64]  ^ w0n;
    w2n      = key_q[63:32]  ^ w1n;
    w3n      = key_q[31:0]   ^ w2n;
    next_key = {w0n, w1n, w2n, w3n};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      key_q     <= '0;
      rcon_q    <= 8'h01;
      round_idx <= '0;
      rk_valid  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_LOAD;
            key_q     <= key_in;
            rcon_q    <= 8'h01;
            round_idx <= '0;
            rk_valid  <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
          end
        end
        S_LOAD, S_EXPAND: begin
          if (round_idx == LAST_ROUND) begin
            state    <= S_IDLE;
            rk_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
          end else begin
            state     <= S_EXPAND;
            key_q     <= next_key;
            rcon_q    <= xtime(rcon_q);
            round_idx <= round_idx + 4'd1;
            done      <= (round_idx == LAST_ROUND - 4'd1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/aes_key_expander.md
Name: aes_key_expander

Overview:
- Iterative AES-128 key schedule stage, directly downstream of the key/data queue.
- When the queue presents a new cipher key on K0..KF, the block expands it into the 11 round keys, one per clock.
- Round keys are presented with a round index to the round datapath, which consumes them alongside the state bytes G0..GF.
- Byte order: K0 is the most significant byte of the 128-bit key, so word w0 = {K0,K1,K2,K3} and w3 = {KC,KD,KE,KF}.

Parameters:
NR, 10, number of expansion rounds after round 0 (AES-128); only 10 is supported.

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  single-cycle request: latch K0..KF and begin expansion
K0..KF  input  8 each  cipher key bytes, K0 = MSB
RK0..RKF  output  8 each  current round key bytes, RK0 = MSB
round_idx  output  4  index of the round key on RK0..RKF (0..10)
rk_valid  output  1  RK/round_idx valid this cycle
busy  output  1  expansion in progress; start is ignored
done  output  1  one-cycle pulse coincident with round_idx=10

Behaviour:
- Reset (synchronous, active-high):
  - RK0..RKF = 0, round_idx = 0, rk_valid = 0, busy = 0, done = 0.
  - Rcon register = 8'h01; FSM goes to IDLE.
  - Reset asserted mid-expansion aborts it; no done pulse is produced.
- FSM states: IDLE, LOAD, EXPAND.
- IDLE:
  - start=1 at edge t captures K0..KF into the key register and moves to LOAD.
  - busy=1 from cycle t+1.
- LOAD (cycle t+1):
  - RK = captured key, round_idx = 0, rk_valid = 1.
  - Next state EXPAND with Rcon = 01.
- EXPAND (cycles t+2 .. t+11):
  - Each cycle computes the next key from the registered current key:
    - tmp = SubWord(RotWord(w3)) XOR {Rcon,00,00,00}
    - w0' = w0^tmp; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'
  - Outputs show the new key with round_idx incremented and rk_valid = 1.
  - Rcon update per round: Rcon = xtime(Rcon), i.e. shift left by 1, XOR 8'h1B if bit 7 was set. Sequence: 01,02,04,08,10,20,40,80,1B,36.
  - The chained w XORs are combinational within one cycle; there is no multicycle path.
- Completion:
  - When round_idx becomes 10: done = 1 and rk_valid = 1 for that cycle.
  - Next cycle returns to IDLE: rk_valid = 0, busy = 0, done = 0.
  - RK0..RKF and round_idx hold their last values in IDLE.
- Latency: round key r appears at cycle t+1+r. Total 11 cycles of rk_valid; no gaps; no backpressure.
- start handling:
  - start while busy=1 is ignored; no queueing, and the current expansion is unaffected.
  - start on the same cycle that done=1 is also ignored, because busy is still high.
  - The earliest accepted restart is the cycle after done.
- reset and start asserted together: reset wins.
- An all-zero key is a legal key and is expanded normally. Delimiter filtering is the queue's job.
- round_idx never exceeds 10; the counter does not wrap.

Decomposition:
- Shared header aes_defs.vh:
  - localparam state encodings S_IDLE=2'd0, S_LOAD=2'd1, S_EXPAND=2'd2.
  - LAST_ROUND = 4'd10.
  - xtime function, reused later by MixColumns.
- Sub-module aes_sbox: combinational, 8-bit in / 8-bit out, forward S-box lookup.
  - Instantiated 4 times for SubWord.
  - The round datapath reuses the same module.
- Top level: FSM, key register, Rcon register, round counter, XOR chain.

Test Plan:
1. FIPS-197 key 000102030405060708090a0b0c0d0e0f, start pulse:
   - round 0 = same key, one cycle later.
   - round 1 = d6aa74fdd2af72fadaa678f1d6ab76fe.
   - round 10 = 13111d7fe3944a17f307a78b4d2b30c5, with done=1 on that cycle only.
2. Key 2b7e151628aed2a6abf7158809cf4f3c:
   - round 1 = a0fafe1788542cb123a339392a6c7605.
   - round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
   - rk_valid high for exactly 11 consecutive cycles.
3. Key 101112131415161718191a1b1c1d1e1f started, then start pulsed again with a different key at round_idx=4 and at the done cycle:
   - both pulses are ignored.
   - round keys match a reference model of the first key only; busy=1 throughout.
4. reset asserted at round_idx=6:
   - next cycle all outputs are 0 and the FSM is IDLE.
   - no done pulse.
   - a subsequent start with the FIPS key reproduces scenario 1 exactly, proving Rcon was reset to 01.
5. Back-to-back operation: start the cycle after done with key 000...0:
   - round 1 = 62636363626363636263636362636363.
   - round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
6. Idle stability: hold start=0 for 20 cycles after reset:
   - rk_valid, busy and done stay 0.
   - RK outputs stay 0.
